// File: rtl/issue_queue_if.sv
// Decoder/executer-facing bundle of the in-order issue queue.
// master = decoder + executer side, slave = the queue itself.
interface issue_queue_if #(
  parameter int OPW = 64
);
  // Both in_* and iss_* are valid/ready: a beat transfers on the rising edge where valid && ready.
  // The sender holds payload stable while valid is high.
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [4:0]     in_rd;
  logic [4:0]     in_rs1;
  logic [4:0]     in_rs2;
  logic [19:0]    in_imm;
  logic [63:0]    in_pc;

  logic           iss_valid;
  logic           iss_ready;
  logic [OPW-1:0] iss_opcode;
  logic [4:0]     iss_rd;
  logic [4:0]     iss_rs1;
  logic [4:0]     iss_rs2;
  logic [19:0]    iss_imm;
  logic [63:0]    iss_pc;

  logic           wb_valid;
  logic [4:0]     wb_rd;
  logic           flush;
  logic [31:0]    busy;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, in_pc,
    output iss_ready, wb_valid, wb_rd, flush,
    input  in_ready, iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc,
    input  busy
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, in_pc,
    input  iss_ready, wb_valid, wb_rd, flush,
    output in_ready, iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_pc,
    output busy
  );
endinterface

// File: rtl/issue_queue.sv
// In-order issue queue: DEPTH-entry FIFO plus a 32-bit pending-writer scoreboard.
// Optional macro ISSUE_BYPASS_EN lets a same-cycle writeback unblock the head op.
module issue_queue #(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int OPW   = 64
) (
  input  logic          clk,
  input  logic          reset,
  issue_queue_if.slave  io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [4:0]     rd;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [19:0]    imm;
    logic [63:0]    pc;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    busy_q, busy_d;

  entry_t         head_e;
  entry_t         in_e;
  logic [31:0]    wbclr;
  logic [31:0]    setm;
  logic [31:0]    busy_chk;
  logic           hz;
  logic           enq;
  logic           deq;

  always_comb begin
    head_e = mem_q[head_q];
    in_e   = {io.in_opcode, io.in_rd, io.in_rs1, io.in_rs2, io.in_imm, io.in_pc};
    wbclr  = '0;
    if (io.wb_valid) wbclr[io.wb_rd] = 1'b1;
    wbclr[0] = 1'b0;
`ifdef ISSUE_BYPASS_EN
    busy_chk = busy_q & ~wbclr;
`else
    busy_chk = busy_q;
`endif
    // busy bit 0 is never set, so x0 operands cannot hazard.
    hz = busy_chk[head_e.rd] | busy_chk[head_e.rs1] | busy_chk[head_e.rs2];
  end

  assign io.in_ready   = (count_q != CW'(DEPTH));
  assign io.iss_valid  = (count_q != '0) && !hz;
  assign io.iss_opcode = head_e.opcode;
  assign io.iss_rd     = head_e.rd;
  assign io.iss_rs1    = head_e.rs1;
  assign io.iss_rs2    = head_e.rs2;
  assign io.iss_imm    = head_e.imm;
  assign io.iss_pc     = head_e.pc;
  assign io.busy       = busy_q;

  assign enq = io.in_valid && io.in_ready;
  assign deq = io.iss_valid && io.iss_ready;

  always_comb begin
    setm = '0;
    if (deq) setm[head_e.rd] = 1'b1;
    setm[0] = 1'b0;
    // Clear first, then set: an issuing writer wins over a same-register completion.
    busy_d  = (busy_q & ~wbclr) | setm;

    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (io.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = in_e;
        tail_d        = tail_q + 1'b1;
      end
      if (deq) head_d = head_q + 1'b1;
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a queue-based model of the issue rules.
module tb_issue_queue;
  localparam int DEPTH = 4;
  localparam int OPW   = 64;
  localparam logic [63:0] ADDI = 64'h0000_0000_6164_6469;
  localparam logic [63:0] ADD  = 64'h0000_0000_0061_6464;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [4:0]     rd;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [19:0]    imm;
    logic [63:0]    pc;
  } op_t;

  logic clk;
  logic reset;
  issue_queue_if #(.OPW(OPW)) bus ();

  issue_queue #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          errors = 0;
  int          checks = 0;
  op_t         exp_q[$];
  logic [31:0] m_busy = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wbclr();
    logic [31:0] c;
    c = '0;
    if (bus.wb_valid && bus.wb_rd != 5'd0) c = 32'd1 << bus.wb_rd;
    return c;
  endfunction

  function automatic logic m_iss_valid();
    logic [31:0] eff;
    op_t h;
    if (exp_q.size() == 0) return 1'b0;
    h   = exp_q[0];
    eff = m_busy;
`ifdef ISSUE_BYPASS_EN
    eff = eff & ~m_wbclr();
`endif
    return !((h.rd  != 0 && eff[h.rd])  ||
             (h.rs1 != 0 && eff[h.rs1]) ||
             (h.rs2 != 0 && eff[h.rs2]));
  endfunction

  function automatic logic m_in_ready();
    return exp_q.size() != DEPTH;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_busy = '0;
  endtask

  task automatic model_step();
    logic enq, deq;
    op_t  h, n;
    enq = bus.in_valid && m_in_ready();
    deq = m_iss_valid() && bus.iss_ready;
    n   = {bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_pc};
    m_busy = m_busy & ~m_wbclr();
    if (deq) begin
      h = exp_q[0];
      if (h.rd != 0) m_busy[h.rd] = 1'b1;
    end
    if (bus.flush) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back(n);
    end
  endtask

  task automatic compare();
    logic v;
    op_t  h;
    v = m_iss_valid();
    chk("in_ready", 64'(bus.in_ready), 64'(m_in_ready()));
    chk("iss_valid", 64'(bus.iss_valid), 64'(v));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    if (v) begin
      h = exp_q[0];
      chk("iss_opcode", bus.iss_opcode, h.opcode);
      chk("iss_rd", 64'(bus.iss_rd), 64'(h.rd));
      chk("iss_rs1", 64'(bus.iss_rs1), 64'(h.rs1));
      chk("iss_rs2", 64'(bus.iss_rs2), 64'(h.rs2));
      chk("iss_imm", 64'(bus.iss_imm), 64'(h.imm));
      chk("iss_pc", bus.iss_pc, h.pc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.in_pc     = '0;
    bus.iss_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [63:0] opc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [19:0] imm, input logic [63:0] pc);
    bus.in_valid  = v;
    bus.in_opcode = opc;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_pc     = pc;
  endtask

  // Inputs are driven after a negedge; outputs are checked 1 time unit later.
  task automatic step();
    #1 compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reset = 1'b1;
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_iss_opcode", bus.iss_opcode, 64'd0);
    chk("rst_iss_pc", bus.iss_pc, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill with iss_ready low, then drain in order; 5th op waits for space.
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, ADD, 5'(10 + k), 5'd0, 5'd0, 20'(k), 64'h1000 + 64'(4 * k));
      step();
    end
    set_in(1'b1, ADD, 5'd14, 5'd0, 5'd0, 20'd4, 64'h1010);
    #1 chk("fill_full", 64'(bus.in_ready), 64'd0);
    step();
    chk("fill_held", 64'(bus.in_ready), 64'd0);
    bus.iss_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) bus.in_valid = 1'b0;
      #1;
      chk("fill_order_rd", 64'(bus.iss_rd), 64'(10 + j));
      chk("fill_order_v", 64'(bus.iss_valid), 64'd1);
      step();
    end
    chk("fill_busy", 64'(bus.busy), 64'h0000_7C00);

    // RAW stall on rd=5.
    do_reset();
    set_in(1'b1, ADDI, 5'd5, 5'd0, 5'd0, 20'hFFFFF, 64'h2000);
    step();
    set_in(1'b1, ADD, 5'd6, 5'd5, 5'd0, 20'd0, 64'h2004);
    bus.iss_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1 chk("raw_stall", 64'(bus.iss_valid), 64'd0);
      step();
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
`ifdef ISSUE_BYPASS_EN
    #1 chk("raw_wb_cycle", 64'(bus.iss_valid), 64'd1);
    step();
    bus.wb_valid = 1'b0;
    #1 chk("raw_after_busy", 64'(bus.busy), 64'h0000_0040);
`else
    #1 chk("raw_wb_cycle", 64'(bus.iss_valid), 64'd0);
    step();
    bus.wb_valid = 1'b0;
    #1 chk("raw_after_wb", 64'(bus.iss_valid), 64'd1);
    chk("raw_after_rd", 64'(bus.iss_rd), 64'd6);
`endif
    step();

    // Set-wins: issue of rd=7 coincides with wb of rd=7.
    do_reset();
    set_in(1'b1, ADDI, 5'd7, 5'd1, 5'd0, 20'd3, 64'h3000);
    step();
    bus.in_valid  = 1'b0;
    bus.iss_ready = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd7;
    step();
    bus.wb_valid = 1'b0;
    #1 chk("setwins_busy", 64'(bus.busy), 64'h0000_0080);
    step();

    // x0: repeated addi x0,x0 never stalls; wb of x0 is ignored.
    do_reset();
    bus.iss_ready = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd0;
    for (int j = 0; j < 5; j++) begin
      set_in(1'b1, ADDI, 5'd0, 5'd0, 5'd0, 20'(j), 64'h4000 + 64'(4 * j));
      if (j > 0) #1 chk("x0_issue", 64'(bus.iss_valid), 64'd1);
      step();
    end
    idle();
    #1 chk("x0_busy", 64'(bus.busy), 64'd0);
    step();

    // Flush with busy[3] set and a same-cycle issue of rd=9.
    do_reset();
    set_in(1'b1, ADD, 5'd3, 5'd0, 5'd0, 20'd0, 64'h5000);
    step();
    set_in(1'b1, ADD, 5'd9, 5'd0, 5'd0, 20'd0, 64'h5004);
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    set_in(1'b1, ADD, 5'd20, 5'd3, 5'd0, 20'd0, 64'h5008);
    step();
    set_in(1'b1, ADD, 5'd21, 5'd0, 5'd0, 20'd0, 64'h500C);
    step();
    bus.in_valid  = 1'b0;
    bus.iss_ready = 1'b1;
    bus.flush     = 1'b1;
    #1 chk("flush_pre_rd", 64'(bus.iss_rd), 64'd9);
    step();
    idle();
    #1;
    chk("flush_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_busy", 64'(bus.busy), 64'h0000_0208);
    step();

    // Async reset between edges with 2 ops queued.
    do_reset();
    set_in(1'b1, ADD, 5'd1, 5'd0, 5'd0, 20'd1, 64'h6000);
    step();
    set_in(1'b1, ADD, 5'd2, 5'd0, 5'd0, 20'd2, 64'h6004);
    step();
    idle();
    #2 chk("pre_arst_valid", 64'(bus.iss_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_iss_pc", bus.iss_pc, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic over a small register window to force hazards.
    for (int c = 0; c < 1500; c++) begin
      set_in(($urandom_range(0, 3) != 0),
             {$urandom(), $urandom()},
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             20'($urandom()), {$urandom(), $urandom()});
      bus.iss_ready = ($urandom_range(0, 3) != 0);
      bus.wb_valid  = ($urandom_range(0, 2) == 0);
      bus.wb_rd     = 5'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
